// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch stage.
package if_pkg;

  localparam int unsigned IF_DEFAULT_DEPTH = 4;
  localparam logic [31:0] IF_RESET_PC      = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] if_word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular prefetch queue with push/pop/flush, occupancy count and
// combinational head read.
module ifq_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = IF_DEFAULT_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  if_entry_t       push_data,
  input  logic            pop,
  input  logic            flush,
  output logic [CW-1:0]   count,
  output if_entry_t       head
);

  if_entry_t       mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop  && !flush && !empty;

  // Storage and pointers; flush only rewinds pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
    end else begin
      if (do_push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + PW'(1);
      end
      if (do_pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
  assign head  = mem[head_ptr];

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: pc/issue control over a 1-cycle-latency imem and a
// prefetch queue feeding decode. Optional perf counters under IF_PERF_CNT_EN.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int unsigned DEPTH    = IF_DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc;
  logic [31:0]   fetch_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW-1:0] credit;
  logic          push;
  logic          pop;
  if_entry_t     push_data;
  if_entry_t     head;

  // Issue only while queued plus in-flight entries leave a free slot.
  assign credit    = count + CW'(inflight);
  assign imem_req  = reset && !redirect && (credit < CW'(DEPTH));
  assign imem_addr = pc;

  assign push      = inflight && !redirect;
  assign pop       = id_valid && id_ready && !redirect;
  assign push_data = '{pc: fetch_pc, instr: imem_rdata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      fetch_pc <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      pc       <= if_word_align(redirect_pc);
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc       <= pc + 32'd4;
        fetch_pc <= pc;
      end
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  assign id_valid    = (count != '0);
  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  assign id_pc_plus4 = head.pc + 32'd4;

`ifdef IF_PERF_CNT_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (imem_req) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
